nysa_sdio_cmd_deframer: RTL and testbench
=========================================

NYSA_SDIO_CMD_DEFRAMER -- requirements
Module: nysa_sdio_cmd_deframer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: write-data word width in bits, multiple of 8, 8..64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address field width in bits, multiple of 8, 8..32.
REQ-003 SHALL have parameter COUNT_WIDTH, default 16: word-count field width in bits, multiple of 8, 8..32.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024: mid-packet idle limit in cycles, at least 2.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port i_in_valid  input  1  byte from SDIO function valid.
REQ-008 SHALL have port i_in_data  input  8  ingress byte.
REQ-009 SHALL have port o_in_ready  output  1  byte accepted when i_in_valid and o_in_ready are both 1.
REQ-010 SHALL have port o_cmd_valid / i_cmd_ready  output/input  1 each  command handshake.
REQ-011 SHALL have port o_cmd  output  8  command byte; bit0=1 write, bit0=0 read.
REQ-012 SHALL have port o_cmd_count  output  COUNT_WIDTH  word count.
REQ-013 SHALL have port o_cmd_addr  output  ADDR_WIDTH  start address.
REQ-014 SHALL have port o_wr_valid / i_wr_ready  output/input  1 each  write-word handshake.
REQ-015 SHALL have port o_wr_data  output  DATA_WIDTH  assembled write word.
REQ-016 SHALL have port o_sync_err  output  1  one-cycle pulse on a discarded non-sync byte.
REQ-017 SHALL have port o_timeout  output  1  one-cycle pulse on packet abort.

Function
REQ-018 Packet format SHALL be: SYNC 0xCD, CMD byte, COUNT (COUNT_WIDTH/8 bytes), ADDR (ADDR_WIDTH/8 bytes), then for writes only COUNT words of DATA_WIDTH/8 bytes; all multi-byte fields MSB first.
REQ-019 FSM states SHALL be IDLE, CMD, COUNT, ADDR, ISSUE, DATA.
REQ-020 Transitions on byte accept: IDLE->CMD on 0xCD; CMD->COUNT; COUNT->ADDR after the last count byte; ADDR->ISSUE after the last address byte.
REQ-021 In IDLE a byte other than 0xCD SHALL be consumed and discarded, and o_sync_err SHALL pulse the following cycle.
REQ-022 o_cmd_valid SHALL assert the cycle after the last ADDR byte is accepted and hold with stable fields until i_cmd_ready.
REQ-023 On the command handshake: write with count>0 -> DATA; read, or write with count=0 -> IDLE.
REQ-024 o_in_ready SHALL be 1 in IDLE, CMD, COUNT, ADDR; 0 in ISSUE; in DATA it SHALL equal NOT o_wr_valid.
REQ-025 In DATA, o_wr_valid SHALL assert the cycle after the last byte of a word is accepted and hold with stable o_wr_data until i_wr_ready.
REQ-026 Each write handshake SHALL decrement the remaining count; the handshake that brings it to 0 SHALL move to IDLE.
REQ-027 Byte accept and the following SYNC SHALL proceed without a bubble: the cycle after the last handshake, IDLE accepts a byte.
REQ-028 Count arithmetic SHALL be COUNT_WIDTH-bit unsigned; count 2^COUNT_WIDTH-1 SHALL be transferred fully with no wrap.

Reset
REQ-029 While rst=0 at a clock edge: state=IDLE; o_in_ready=0; o_cmd_valid, o_wr_valid, o_sync_err, o_timeout=0; o_cmd, o_cmd_count, o_cmd_addr, o_wr_data=0; counters=0.
REQ-030 Reset asserted mid-packet SHALL discard all partial state; the first cycle after release o_in_ready=1 in IDLE.

Configuration
REQ-031 Macro NYSA_SDIO_DEFRAMER_TIMEOUT_EN SHALL compile in the timeout.
REQ-032 With it: the idle counter increments each cycle in CMD/COUNT/ADDR, or in DATA with o_wr_valid=0, when no byte is accepted; it clears on accept and in other states; on reaching TIMEOUT_CYCLES the FSM goes to IDLE, drops partial data, and o_timeout pulses once.
REQ-033 Without it: no counter logic; o_timeout is tied to 0; the FSM waits indefinitely.

Verification
REQ-034 Reset mid-packet: reset during ADDR -> all outputs 0; then CD 00 0000 00001000 -> read cmd, count=0, addr=0x1000.
REQ-035 Write: CD 01 0002 00000010 11223344 55667788 -> cmd handshake; then o_wr_data 0x11223344 then 0x55667788; back in IDLE.
REQ-036 Backpressure: i_wr_ready=0 for 5 cycles -> o_in_ready=0 and o_wr_data stable throughout; no byte lost.
REQ-037 Bad sync: bytes AA CD 00 ... -> one o_sync_err pulse; the packet starting at CD is decoded correctly.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=16): stall 16 cycles after CMD -> o_timeout pulse, IDLE; a subsequent full packet decodes.
REQ-039 Write count=0 -> command issued, no o_wr_valid, next SYNC accepted the cycle after the handshake.

Source files
------------

// File: rtl/nysa_sdio_cmd_deframer.sv
// nysa_sdio_cmd_deframer
// Turns the SDIO function's ingress byte stream into command headers
// (cmd, count, addr) and, for writes, a sequence of assembled data words.
// Packet layout: 0xCD, CMD, COUNT (MSB first), ADDR (MSB first), then COUNT
// words of DATA_WIDTH/8 bytes (MSB first) for writes only.
// Optional feature: define NYSA_SDIO_DEFRAMER_TIMEOUT_EN to abort a packet that
// stalls mid-stream for TIMEOUT_CYCLES cycles; without it o_timeout is tied low.

module nysa_sdio_cmd_deframer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_in_valid,
    input  logic [7:0]             i_in_data,
    output logic                   o_in_ready,
    output logic                   o_cmd_valid,
    input  logic                   i_cmd_ready,
    output logic [7:0]             o_cmd,
    output logic [COUNT_WIDTH-1:0] o_cmd_count,
    output logic [ADDR_WIDTH-1:0]  o_cmd_addr,
    output logic                   o_wr_valid,
    input  logic                   i_wr_ready,
    output logic [DATA_WIDTH-1:0]  o_wr_data,
    output logic                   o_sync_err,
    output logic                   o_timeout
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_COUNT = 3'd2;
    localparam logic [2:0] ST_ADDR  = 3'd3;
    localparam logic [2:0] ST_ISSUE = 3'd4;
    localparam logic [2:0] ST_DATA  = 3'd5;

    localparam logic [7:0] SYNC_BYTE = 8'hCD;

    // Index of the last byte of each multi-byte field (fields are at most 8 bytes).
    localparam logic [2:0] COUNT_LAST = 3'(COUNT_WIDTH / 8 - 1);
    localparam logic [2:0] ADDR_LAST  = 3'(ADDR_WIDTH / 8 - 1);
    localparam logic [2:0] DATA_LAST  = 3'(DATA_WIDTH / 8 - 1);

    logic [2:0]             r_state;
    logic [2:0]             r_byte_idx;
    logic [7:0]             r_cmd;
    logic [COUNT_WIDTH-1:0] r_cmd_count;
    logic [ADDR_WIDTH-1:0]  r_cmd_addr;
    logic                   r_cmd_valid;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic [DATA_WIDTH-1:0]  r_wr_data;
    logic                   r_wr_valid;
    logic                   r_sync_err;

    logic w_in_ready;
    logic w_accept;
    logic w_abort;

    // Byte-ready decode from the current state; forced low while reset is held.
    always_comb begin
        // NOTE: default assignment first, so every path drives w_in_ready and no latch is inferred.
        w_in_ready = 1'b0;
        case (r_state)
            ST_IDLE, ST_CMD, ST_COUNT, ST_ADDR: w_in_ready = 1'b1;
            ST_DATA:                            w_in_ready = ~r_wr_valid;
            default:                            w_in_ready = 1'b0;
        endcase
        if (!rst) begin
            w_in_ready = 1'b0;
        end
    end

    assign w_accept = i_in_valid && w_in_ready;

`ifdef NYSA_SDIO_DEFRAMER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_timeout;
    logic              w_idle_tick;

    // A stalled cycle is one inside a packet where we could take a byte but none arrives.
    always_comb begin
        w_idle_tick = 1'b0;
        case (r_state)
            ST_CMD, ST_COUNT, ST_ADDR: w_idle_tick = ~w_accept;
            ST_DATA:                   w_idle_tick = ~r_wr_valid & ~w_accept;
            default:                   w_idle_tick = 1'b0;
        endcase
    end

    // The stall that would make the count reach TIMEOUT_CYCLES aborts the packet.
    assign w_abort = w_idle_tick && (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Stall counter plus the single-cycle abort pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idle_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_abort;
            if (w_idle_tick && !w_abort) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_abort   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Packet FSM: header parsing, command issue and write-word assembly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_byte_idx  <= '0;
            r_cmd       <= '0;
            r_cmd_count <= '0;
            r_cmd_addr  <= '0;
            r_cmd_valid <= 1'b0;
            r_remaining <= '0;
            r_wr_data   <= '0;
            r_wr_valid  <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge register values.
            r_sync_err <= 1'b0;
            if (w_abort) begin
                r_state     <= ST_IDLE;
                r_byte_idx  <= '0;
                r_remaining <= '0;
                r_wr_data   <= '0;
                r_wr_valid  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            if (i_in_data == SYNC_BYTE) begin
                                r_state <= ST_CMD;
                            end else begin
                                r_sync_err <= 1'b1;
                            end
                        end
                    end

                    ST_CMD: begin
                        if (w_accept) begin
                            r_cmd      <= i_in_data;
                            r_byte_idx <= '0;
                            r_state    <= ST_COUNT;
                        end
                    end

                    ST_COUNT: begin
                        if (w_accept) begin
                            r_cmd_count <= (r_cmd_count << 8) | COUNT_WIDTH'(i_in_data);
                            if (r_byte_idx == COUNT_LAST) begin
                                r_byte_idx <= '0;
                                r_state    <= ST_ADDR;
                            end else begin
                                r_byte_idx <= r_byte_idx + 3'd1;
                            end
                        end
                    end

                    ST_ADDR: begin
                        if (w_accept) begin
                            r_cmd_addr <= (r_cmd_addr << 8) | ADDR_WIDTH'(i_in_data);
                            if (r_byte_idx == ADDR_LAST) begin
                                r_byte_idx  <= '0;
                                r_cmd_valid <= 1'b1;
                                r_state     <= ST_ISSUE;
                            end else begin
                                r_byte_idx <= r_byte_idx + 3'd1;
                            end
                        end
                    end

                    ST_ISSUE: begin
                        if (i_cmd_ready) begin
                            r_cmd_valid <= 1'b0;
                            if (r_cmd[0] && (r_cmd_count != '0)) begin
                                r_remaining <= r_cmd_count;
                                r_byte_idx  <= '0;
                                r_state     <= ST_DATA;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (r_wr_valid) begin
                            // Bytes are refused while a word waits, so the word stays stable.
                            if (i_wr_ready) begin
                                r_wr_valid  <= 1'b0;
                                r_remaining <= r_remaining - COUNT_WIDTH'(1);
                                if (r_remaining == COUNT_WIDTH'(1)) begin
                                    r_state <= ST_IDLE;
                                end
                            end
                        end else if (w_accept) begin
                            r_wr_data <= (r_wr_data << 8) | DATA_WIDTH'(i_in_data);
                            if (r_byte_idx == DATA_LAST) begin
                                r_byte_idx <= '0;
                                r_wr_valid <= 1'b1;
                            end else begin
                                r_byte_idx <= r_byte_idx + 3'd1;
                            end
                        end
                    end

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd       = r_cmd;
    assign o_cmd_count = r_cmd_count;
    assign o_cmd_addr  = r_cmd_addr;
    assign o_wr_valid  = r_wr_valid;
    assign o_wr_data   = r_wr_data;
    assign o_sync_err  = r_sync_err;

endmodule

// File: tb/tb_nysa_sdio_cmd_deframer.sv
// Self-checking bench for nysa_sdio_cmd_deframer.
// Packets are described as (cmd, count, addr, words); the bench serialises them
// to bytes and queues the transaction it expects back. A monitor pops the queue
// on every command / write handshake. A second, all-8-bit instance transfers the
// largest possible count (255 words).

module tb_nysa_sdio_cmd_deframer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 16;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic          in_valid, in_ready, cmd_valid, cmd_ready, wr_valid, wr_ready;
    logic [7:0]    in_data, cmd;
    logic [CW-1:0] cmd_count;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] wr_data;
    logic          sync_err, timeout;

    nysa_sdio_cmd_deframer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd(cmd),
        .o_cmd_count(cmd_count), .o_cmd_addr(cmd_addr),
        .o_wr_valid(wr_valid), .i_wr_ready(wr_ready), .o_wr_data(wr_data),
        .o_sync_err(sync_err), .o_timeout(timeout)
    );

    // all-8-bit instance for the maximum-count transfer
    logic       b_in_valid, b_in_ready, b_cmd_valid, b_cmd_ready, b_wr_valid, b_wr_ready;
    logic [7:0] b_in_data, b_cmd, b_cmd_count, b_cmd_addr, b_wr_data;
    logic       b_sync_err, b_timeout;

    nysa_sdio_cmd_deframer #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .COUNT_WIDTH(8), .TIMEOUT_CYCLES(TO)
    ) dut_b (
        .clk(clk), .rst(rst),
        .i_in_valid(b_in_valid), .i_in_data(b_in_data), .o_in_ready(b_in_ready),
        .o_cmd_valid(b_cmd_valid), .i_cmd_ready(b_cmd_ready), .o_cmd(b_cmd),
        .o_cmd_count(b_cmd_count), .o_cmd_addr(b_cmd_addr),
        .o_wr_valid(b_wr_valid), .i_wr_ready(b_wr_ready), .o_wr_data(b_wr_data),
        .o_sync_err(b_sync_err), .o_timeout(b_timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0]    cmd;
        logic [CW-1:0] count;
        logic [AW-1:0] addr;
    } cmd_t;

    cmd_t          exp_cmd_q[$];
    logic [DW-1:0] exp_wr_q[$];
    logic [DW-1:0] data_q[$];     // optional fixed payload for the next write packet
    int            exp_sync = 0, n_sync = 0;
    int            exp_to   = 0, n_to   = 0;
    bit            rand_bp      = 1'b0;
    bit            force_wr_low = 1'b0;

    // Downstream ready driver: always ready, random, or held off on request.
    initial begin
        cmd_ready   = 1'b1;
        wr_ready    = 1'b1;
        b_cmd_ready = 1'b1;
        b_wr_ready  = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cmd_ready  = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_ready   = force_wr_low ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
            b_wr_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor for the main instance: scoreboard pops plus handshake-protocol rules.
    cmd_t          mon_e;
    logic          p_cmd_valid = 1'b0, p_cmd_ready = 1'b0, p_wr_valid = 1'b0, p_wr_ready = 1'b0;
    logic [55:0]   p_cmd_fields;
    logic [DW-1:0] p_wr_data;

    always @(negedge clk) begin
        if (!rst) begin
            p_cmd_valid = 1'b0;
            p_wr_valid  = 1'b0;
        end else begin
            if (sync_err) n_sync++;
            if (timeout)  n_to++;
            if (cmd_valid) check("in_ready low while cmd pending", in_ready, 0);
            if (wr_valid)  check("in_ready low while word pending", in_ready, 0);
            if (p_cmd_valid && !p_cmd_ready) begin
                check("cmd_valid held", cmd_valid, 1);
                check("cmd fields stable", {cmd, cmd_count, cmd_addr}, p_cmd_fields);
            end
            if (p_wr_valid && !p_wr_ready) begin
                check("wr_valid held", wr_valid, 1);
                check("wr_data stable", wr_data, p_wr_data);
            end
            if (cmd_valid && cmd_ready) begin
                if (exp_cmd_q.size() == 0) begin
                    check("unexpected cmd handshake", cmd_valid, 0);
                end else begin
                    mon_e = exp_cmd_q.pop_front();
                    check("cmd byte", cmd, mon_e.cmd);
                    check("cmd count", cmd_count, mon_e.count);
                    check("cmd addr", cmd_addr, mon_e.addr);
                end
            end
            if (wr_valid && wr_ready) begin
                if (exp_wr_q.size() == 0) begin
                    check("unexpected write word", wr_valid, 0);
                end else begin
                    check("write word", wr_data, exp_wr_q.pop_front());
                end
            end
            p_cmd_valid  = cmd_valid;
            p_cmd_ready  = cmd_ready;
            p_cmd_fields = {cmd, cmd_count, cmd_addr};
            p_wr_valid   = wr_valid;
            p_wr_ready   = wr_ready;
            p_wr_data    = wr_data;
        end
    end

    // Monitor for the 8-bit instance: word k of the long transfer is k ^ 0x5A.
    int b_words = 0, b_cmds = 0;
    always @(negedge clk) begin
        if (rst) begin
            if (b_cmd_valid && b_cmd_ready) begin
                b_cmds++;
                check("w8 cmd", b_cmd, 8'h01);
                check("w8 count", b_cmd_count, 8'hFF);
                check("w8 addr", b_cmd_addr, 8'hA5);
            end
            if (b_wr_valid && b_wr_ready) begin
                check("w8 word", b_wr_data, 8'(b_words) ^ 8'h5A);
                b_words++;
            end
        end
    end

    // Offer one byte and hold it until accepted; 'waited' counts refused cycles.
    task automatic send_byte(input logic [7:0] b, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready wait bound", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serialise a packet and queue what should come back; the first 'skip' bytes
    // are assumed to have been sent already by the caller.
    task automatic send_packet(input logic [7:0] c, input logic [CW-1:0] n,
                               input logic [AW-1:0] a, input int max_gap, input int skip);
        logic [7:0]    bytes[$];
        logic [DW-1:0] w;
        int            waited;
        bytes.push_back(8'hCD);
        bytes.push_back(c);
        for (int i = CW / 8 - 1; i >= 0; i--) bytes.push_back(n[i*8 +: 8]);
        for (int i = AW / 8 - 1; i >= 0; i--) bytes.push_back(a[i*8 +: 8]);
        exp_cmd_q.push_back('{cmd: c, count: n, addr: a});
        if (c[0]) begin
            for (int k = 0; k < int'(n); k++) begin
                w = (data_q.size() > 0) ? data_q.pop_front() : DW'($urandom);
                exp_wr_q.push_back(w);
                for (int i = DW / 8 - 1; i >= 0; i--) bytes.push_back(w[i*8 +: 8]);
            end
        end
        for (int i = skip; i < bytes.size(); i++) begin
            send_byte(bytes[i], waited);
            if (max_gap > 0) idle_cycles($urandom_range(0, max_gap));
        end
    endtask

    // Wait (bounded) for every queued expectation to be consumed.
    task automatic drain();
        int n = 0;
        while ((exp_cmd_q.size() != 0 || exp_wr_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cmd queue drained", 64'(exp_cmd_q.size()), 0);
        check("wr queue drained", 64'(exp_wr_q.size()), 0);
        idle_cycles(2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " in_ready"}, in_ready, 0);
        check({tag, " cmd_valid"}, cmd_valid, 0);
        check({tag, " wr_valid"}, wr_valid, 0);
        check({tag, " sync_err"}, sync_err, 0);
        check({tag, " timeout"}, timeout, 0);
        check({tag, " cmd"}, cmd, 0);
        check({tag, " count"}, cmd_count, 0);
        check({tag, " addr"}, cmd_addr, 0);
        check({tag, " wr_data"}, wr_data, 0);
    endtask

    task automatic send_byte_b(input logic [7:0] b);
        int waited = 0;
        b_in_valid = 1'b1;
        b_in_data  = b;
        @(negedge clk);
        while (!b_in_ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!b_in_ready) check("w8 in_ready wait bound", b_in_ready, 1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         waited;
        int         n;
        logic [7:0] c, g;
        logic [CW-1:0] cnt;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        b_in_valid = 1'b0;
        b_in_data  = 8'h00;

        // power-on reset
        idle_cycles(3);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("in_ready after reset release", in_ready, 1);
        @(posedge clk);
        #1;

        // reset in the middle of the address field discards the partial packet
        send_byte(8'hCD, waited);
        send_byte(8'h01, waited);
        send_byte(8'h00, waited);
        send_byte(8'h02, waited);
        send_byte(8'h00, waited);
        send_byte(8'h00, waited);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("mid-packet reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("in_ready first cycle after release", in_ready, 1);
        @(posedge clk);
        #1;
        send_packet(8'h00, 16'h0000, 32'h0000_1000, 0, 0);
        drain();

        // directed two-word write
        data_q.push_back(32'h1122_3344);
        data_q.push_back(32'h5566_7788);
        send_packet(8'h01, 16'h0002, 32'h0000_0010, 0, 0);
        drain();
        check("idle after write in_ready", in_ready, 1);
        check("idle after write wr_valid", wr_valid, 0);

        // write-side backpressure held for five cycles
        force_wr_low = 1'b1;
        fork
            send_packet(8'h01, 16'h0002, 32'h0000_0020, 0, 0);
            begin : hold_off
                logic [DW-1:0] held;
                n = 0;
                @(negedge clk);
                while (!wr_valid && n < 300) begin
                    n++;
                    @(negedge clk);
                end
                check("bp word presented", wr_valid, 1);
                held = wr_data;
                repeat (5) begin
                    @(negedge clk);
                    check("bp in_ready low", in_ready, 0);
                    check("bp wr_valid held", wr_valid, 1);
                    check("bp wr_data held", wr_data, held);
                end
                force_wr_low = 1'b0;
            end
        join
        drain();

        // a stray byte before the sync is dropped with one sync_err pulse
        send_byte(8'hAA, waited);
        exp_sync++;
        @(negedge clk);
        check("sync_err pulse after stray byte", sync_err, 1);
        @(posedge clk);
        #1;
        send_packet(8'h00, 16'h0005, 32'h0000_0040, 0, 0);
        drain();
        check("sync_err pulse count", n_sync, exp_sync);

        // zero-count write: command only, next sync accepted right after the handshake
        send_packet(8'h01, 16'h0000, 32'h0000_0080, 0, 0);
        check("cmd_valid after last addr byte", cmd_valid, 1);
        send_byte(8'hCD, waited);
        check("sync refused cycles after zero-count write", waited, 1);
        send_packet(8'h00, 16'h0003, 32'h0000_0090, 0, 1);
        drain();

`ifdef NYSA_SDIO_DEFRAMER_TIMEOUT_EN
        // 15 stalled cycles is still tolerated
        send_byte(8'hCD, waited);
        send_byte(8'h01, waited);
        idle_cycles(TO - 1);
        check("no timeout one cycle early", timeout, 0);
        send_packet(8'h01, 16'h0001, 32'h0000_00A0, 0, 2);
        drain();
        // 16 stalled cycles aborts the packet
        send_byte(8'hCD, waited);
        send_byte(8'h01, waited);
        send_byte(8'h00, waited);
        idle_cycles(TO - 1);
        check("timeout not yet", timeout, 0);
        idle_cycles(1);
        check("timeout pulse", timeout, 1);
        check("idle after timeout", in_ready, 1);
        exp_to++;
        idle_cycles(1);
        check("timeout single pulse", timeout, 0);
        send_packet(8'h01, 16'h0002, 32'h0000_00B0, 0, 0);
        drain();
`else
        // without the timeout the parser waits indefinitely
        send_byte(8'hCD, waited);
        send_byte(8'h01, waited);
        idle_cycles(3 * TO);
        check("timeout tied low", timeout, 0);
        send_packet(8'h01, 16'h0001, 32'h0000_00A0, 0, 2);
        drain();
`endif
        check("timeout pulse count", n_to, exp_to);

        // randomized traffic with random gaps and random backpressure
        rand_bp = 1'b1;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    g = 8'($urandom);
                    if (g == 8'hCD) g = 8'h3C;
                    send_byte(g, waited);
                    exp_sync++;
                end
            end
            c   = 8'($urandom);
            cnt = c[0] ? CW'($urandom_range(0, 4)) : CW'($urandom);
            send_packet(c, cnt, AW'($urandom), 3, 0);
        end
        drain();
        check("random sync_err count", n_sync, exp_sync);
        check("random timeout count", n_to, exp_to);

        // maximum count on the 8-bit instance: 255 words, no wrap
        send_byte_b(8'hCD);
        send_byte_b(8'h01);
        send_byte_b(8'hFF);
        send_byte_b(8'hA5);
        for (int k = 0; k < 255; k++) send_byte_b(8'(k) ^ 8'h5A);
        n = 0;
        while (b_words < 255 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle_cycles(3);
        check("w8 words transferred", b_words, 255);
        check("w8 single command", b_cmds, 1);
        check("w8 idle afterwards", b_in_ready, 1);
        check("w8 no word pending", b_wr_valid, 0);
        check("w8 no sync_err", b_sync_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
